// File: rtl/icache_pkg.sv
// Shared definitions for the direct-mapped instruction cache.
//   fill_state_t : refill FSM state encoding (IDLE=0, REQ=1, FILL=2)
//   NOP          : instruction the F stage may inject while stall=1
//   *_bits()     : address field widths derived from the cache geometry
package icache_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        FILL = 2'd2
    } fill_state_t;

    localparam logic [31:0] NOP = 32'h00000013;

    function automatic int unsigned woff_bits(input int unsigned words_per_line);
        return $clog2(words_per_line);
    endfunction

    function automatic int unsigned idx_bits(input int unsigned num_lines);
        return $clog2(num_lines);
    endfunction

    function automatic int unsigned tag_bits(input int unsigned addr_w,
                                             input int unsigned num_lines,
                                             input int unsigned words_per_line);
        return addr_w - idx_bits(num_lines) - woff_bits(words_per_line) - 2;
    endfunction

endpackage

// File: rtl/icache_refill_fsm.sv
// Line-refill controller for icache_dm.
//   clock, reset         : rising-edge clock, asynchronous active-high reset
//   flush                : invalidate request; poisons an in-flight refill
//   miss, line_addr      : lookup missed in IDLE, and its line-aligned address
//   state                : current FSM state (lookup is only allowed in IDLE)
//   mem_req_valid/addr   : registered line-fill request, held until ready
//   mem_req_ready        : request accepted this cycle
//   mem_resp_valid       : fill beat valid (ignored outside FILL)
//   wr_en, wr_beat       : write strobe and word offset for the incoming beat
//   line_done            : last beat being written (tag update)
//   line_validate        : last beat of an unpoisoned fill (valid-bit set)
module icache_refill_fsm
    import icache_pkg::*;
#(
    parameter  int unsigned ADDR_W         = 32,
    parameter  int unsigned WORDS_PER_LINE = 4,
    localparam int unsigned WOFF_W         = woff_bits(WORDS_PER_LINE)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              flush,
    input  logic              miss,
    input  logic [ADDR_W-1:0] line_addr,
    input  logic              mem_req_ready,
    input  logic              mem_resp_valid,
    output fill_state_t       state,
    output logic              mem_req_valid,
    output logic [ADDR_W-1:0] mem_req_addr,
    output logic              wr_en,
    output logic [WOFF_W-1:0] wr_beat,
    output logic              line_done,
    output logic              line_validate
);

    localparam logic [WOFF_W-1:0] LAST_BEAT = WOFF_W'(WORDS_PER_LINE - 1);

    logic [WOFF_W-1:0] beat;
    logic              poison;

    assign wr_en         = (state == FILL) & mem_resp_valid;
    assign wr_beat       = beat;
    assign line_done     = wr_en & (beat == LAST_BEAT);
    // A flush landing on the final beat must still win over validation.
    assign line_validate = line_done & ~poison & ~flush;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            beat          <= '0;
            poison        <= 1'b0;
            mem_req_valid <= 1'b0;
            mem_req_addr  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (miss) begin
                        mem_req_addr  <= line_addr;
                        mem_req_valid <= 1'b1;
                        state         <= REQ;
                    end
                end
                REQ: begin
                    if (flush) poison <= 1'b1;
                    if (mem_req_ready) begin
                        mem_req_valid <= 1'b0;
                        beat          <= '0;
                        state         <= FILL;
                    end
                end
                FILL: begin
                    if (flush) poison <= 1'b1;
                    if (mem_resp_valid) begin
                        beat <= beat + 1'b1;
                        if (beat == LAST_BEAT) begin
                            poison <= 1'b0;
                            state  <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/icache_dm.sv
// Direct-mapped, read-only instruction cache for the fetch stage.
//   clock, reset       : rising-edge clock, asynchronous active-high reset
//   addr               : fetch byte address (bits [1:0] ignored)
//   flush              : invalidate every line (FENCE.I)
//   instr, hit, stall  : combinational lookup result; instr is 0 on a miss
//   mem_req_*          : line-fill request to next-level memory
//   mem_resp_*         : fill beats, ascending word order
module icache_dm
    import icache_pkg::*;
#(
    parameter int unsigned ADDR_W         = 32,
    parameter int unsigned NUM_LINES      = 16,
    parameter int unsigned WORDS_PER_LINE = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] addr,
    input  logic              flush,
    output logic [31:0]       instr,
    output logic              hit,
    output logic              stall,
    output logic              mem_req_valid,
    output logic [ADDR_W-1:0] mem_req_addr,
    input  logic              mem_req_ready,
    input  logic              mem_resp_valid,
    input  logic [31:0]       mem_resp_data
);

    localparam int unsigned WOFF_W  = woff_bits(WORDS_PER_LINE);
    localparam int unsigned IDX_W   = idx_bits(NUM_LINES);
    localparam int unsigned TAG_W   = tag_bits(ADDR_W, NUM_LINES, WORDS_PER_LINE);
    localparam int unsigned IDX_LSB = 2 + WOFF_W;
    localparam int unsigned TAG_LSB = IDX_LSB + IDX_W;

    logic [31:0]      data_mem [NUM_LINES*WORDS_PER_LINE];
    logic [TAG_W-1:0] tag_mem  [NUM_LINES];
    logic [NUM_LINES-1:0] valid;

    fill_state_t       state;
    logic              miss;
    logic              wr_en;
    logic [WOFF_W-1:0] wr_beat;
    logic              line_done;
    logic              line_validate;
    logic              unused_byte_bits;

    logic [WOFF_W-1:0] woff;
    logic [IDX_W-1:0]  idx;
    logic [TAG_W-1:0]  tag;
    logic [IDX_W-1:0]  fill_idx;
    logic [TAG_W-1:0]  fill_tag;
    logic [ADDR_W-1:0] line_addr;

    assign woff             = addr[IDX_LSB-1:2];
    assign idx              = addr[TAG_LSB-1:IDX_LSB];
    assign tag              = addr[ADDR_W-1:TAG_LSB];
    assign unused_byte_bits = ^addr[1:0];
    assign line_addr        = {addr[ADDR_W-1:IDX_LSB], {IDX_LSB{1'b0}}};

    // Refill targets the latched request address, not the live fetch address.
    assign fill_idx = mem_req_addr[TAG_LSB-1:IDX_LSB];
    assign fill_tag = mem_req_addr[ADDR_W-1:TAG_LSB];

    assign hit   = (state == IDLE) & valid[idx] & (tag_mem[idx] == tag) & ~flush;
    assign stall = ~hit;
    assign instr = hit ? data_mem[{idx, woff}] : '0;
    assign miss  = (state == IDLE) & ~hit;

    icache_refill_fsm #(
        .ADDR_W         (ADDR_W),
        .WORDS_PER_LINE (WORDS_PER_LINE)
    ) u_refill (
        .clock          (clock),
        .reset          (reset),
        .flush          (flush),
        .miss           (miss),
        .line_addr      (line_addr),
        .mem_req_ready  (mem_req_ready),
        .mem_resp_valid (mem_resp_valid),
        .state          (state),
        .mem_req_valid  (mem_req_valid),
        .mem_req_addr   (mem_req_addr),
        .wr_en          (wr_en),
        .wr_beat        (wr_beat),
        .line_done      (line_done),
        .line_validate  (line_validate)
    );

    always_ff @(posedge clock) begin
        if (wr_en) data_mem[{fill_idx, wr_beat}] <= mem_resp_data;
        if (line_done) tag_mem[fill_idx] <= fill_tag;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            valid <= '0;
        end else if (flush) begin
            valid <= '0;
        end else if (line_validate) begin
            valid[fill_idx] <= 1'b1;
        end
    end

endmodule

// File: tb/tb_icache_dm.sv
// Directed self-checking bench for icache_dm (32-bit address, 16 lines, 4 words/line).
module tb_icache_dm;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] addr;
    logic        flush;
    logic [31:0] instr;
    logic        hit;
    logic        stall;
    logic        mem_req_valid;
    logic [31:0] mem_req_addr;
    logic        mem_req_ready;
    logic        mem_resp_valid;
    logic [31:0] mem_resp_data;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    int t_miss;

    always #5 clock = ~clock;

    icache_dm #(
        .ADDR_W         (32),
        .NUM_LINES      (16),
        .WORDS_PER_LINE (4)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .addr           (addr),
        .flush          (flush),
        .instr          (instr),
        .hit            (hit),
        .stall          (stall),
        .mem_req_valid  (mem_req_valid),
        .mem_req_addr   (mem_req_addr),
        .mem_req_ready  (mem_req_ready),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_data  (mem_resp_data)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are checked
    // after a further settle delay, well before the next edge.
    task automatic step();
        @(posedge clock);
        #1;
        cyc++;
    endtask

    task automatic settle();
        #1;
    endtask

    // Backing-store contents: line 0 holds the four given instructions,
    // every other line a pattern unique to (line, word).
    function automatic logic [31:0] mem_word(input logic [31:0] line, input int b);
        logic [31:0] tbl [4];
        tbl[0] = 32'h08000213;
        tbl[1] = 32'h000000b3;
        tbl[2] = 32'h04000113;
        tbl[3] = 32'h000001b3;
        if (line == 32'h0) return tbl[b];
        return 32'hA0000000 ^ line ^ (32'(b) * 32'h01010101);
    endfunction

    // Called in a cycle where the DUT is expected to be in REQ.
    task automatic fill_line(input logic [31:0] line, input int rdy_delay,
                             input int gap, input int flush_beat);
        for (int i = 0; i < rdy_delay; i++) begin
            mem_req_ready = 1'b0;
            settle();
            check("req_valid_hold", 32'(mem_req_valid), 32'd1);
            check("req_addr_hold", mem_req_addr, line);
            step();
        end
        mem_req_ready = 1'b1;
        settle();
        check("req_valid", 32'(mem_req_valid), 32'd1);
        check("req_addr", mem_req_addr, line);
        step();
        mem_req_ready = 1'b0;
        settle();
        check("req_valid_drop", 32'(mem_req_valid), 32'd0);
        for (int b = 0; b < 4; b++) begin
            for (int g = 0; g < gap; g++) begin
                mem_resp_valid = 1'b0;
                mem_resp_data  = 32'hDEADBEEF;
                settle();
                check("fill_gap_stall", 32'(stall), 32'd1);
                step();
            end
            mem_resp_valid = 1'b1;
            mem_resp_data  = mem_word(line, b);
            flush          = (b == flush_beat);
            settle();
            check("fill_beat_hit", 32'(hit), 32'd0);
            step();
        end
        mem_resp_valid = 1'b0;
        mem_resp_data  = '0;
        flush          = 1'b0;
    endtask

    task automatic check_line(input logic [31:0] line);
        for (int w = 0; w < 4; w++) begin
            addr = line + 32'(4 * w);
            settle();
            check("line_hit", 32'(hit), 32'd1);
            check("line_instr", instr, mem_word(line, w));
            step();
        end
    endtask

    initial begin
        reset          = 1'b1;
        addr           = 32'h0;
        flush          = 1'b0;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        mem_resp_data  = '0;
        step(); step(); step();

        // 1. reset state, then request one cycle after the miss
        reset = 1'b0;
        settle();
        check("rst_hit", 32'(hit), 32'd0);
        check("rst_stall", 32'(stall), 32'd1);
        check("rst_instr", instr, 32'h0);
        check("rst_req_valid", 32'(mem_req_valid), 32'd0);
        check("rst_req_addr", mem_req_addr, 32'h0);
        t_miss = cyc;
        step();

        // 2. back-to-back fill, miss-to-hit latency, hit with no stall
        fill_line(32'h0, 0, 0, -1);
        addr = 32'h8;
        settle();
        check("lat_cycles", 32'(cyc - t_miss), 32'd6);
        check("hit_0x8", 32'(hit), 32'd1);
        check("instr_0x8", instr, 32'h04000113);
        check("stall_0x8", 32'(stall), 32'd0);
        step();
        addr = 32'hC;
        settle();
        check("hit_0xC", 32'(hit), 32'd1);
        check("instr_0xC", instr, 32'h000001b3);
        step();

        // 3. conflict at index 0 evicts line 0; other indices stay independent
        addr = 32'h100;
        settle();
        check("conflict_miss", 32'(hit), 32'd0);
        step();
        addr = 32'h4;  // change during REQ/FILL must not matter
        fill_line(32'h100, 0, 0, -1);
        addr = 32'h104;
        settle();
        check("hit_0x104", 32'(hit), 32'd1);
        check("instr_0x104", instr, mem_word(32'h100, 1));
        step();
        addr = 32'h0;
        settle();
        check("evicted_miss", 32'(hit), 32'd0);
        step();
        fill_line(32'h0, 0, 0, -1);
        check_line(32'h0);
        addr = 32'h2C;
        settle();
        check("idx2_miss", 32'(hit), 32'd0);
        step();
        fill_line(32'h20, 0, 0, -1);
        check_line(32'h20);
        addr = 32'h4;
        settle();
        check("idx0_still_hit", 32'(hit), 32'd1);
        check("idx0_still_instr", instr, 32'h000000b3);
        step();

        // 4. delayed ready and gapped response beats
        addr = 32'h40;
        settle();
        check("gap_miss", 32'(hit), 32'd0);
        step();
        fill_line(32'h40, 5, 1, -1);
        check_line(32'h40);

        // 5. flush mid-FILL, flush while warm, flush on the last beat
        addr = 32'h80;
        settle();
        check("poison_miss", 32'(hit), 32'd0);
        step();
        fill_line(32'h80, 0, 0, 1);
        settle();
        check("poison_no_hit", 32'(hit), 32'd0);
        step();
        fill_line(32'h80, 0, 0, -1);
        check_line(32'h80);
        addr  = 32'h80;
        flush = 1'b1;
        settle();
        check("flush_forces_miss", 32'(hit), 32'd0);
        step();
        flush = 1'b0;
        settle();
        check("after_flush_hit", 32'(hit), 32'd0);
        fill_line(32'h80, 0, 0, -1);
        addr = 32'h0;
        settle();
        check("flush_cleared_line0", 32'(hit), 32'd0);
        step();
        fill_line(32'h0, 0, 0, -1);
        check_line(32'h0);
        addr = 32'hC0;
        settle();
        check("lastbeat_miss", 32'(hit), 32'd0);
        step();
        fill_line(32'hC0, 0, 0, 3);
        settle();
        check("lastbeat_flush_no_hit", 32'(hit), 32'd0);
        step();
        fill_line(32'hC0, 0, 0, -1);
        check_line(32'hC0);

        // 6. reset during fill beat 2, stray beats ignored, fresh refill
        addr = 32'h1C0;
        settle();
        check("rstfill_miss", 32'(hit), 32'd0);
        step();
        mem_req_ready = 1'b1;
        step();
        mem_req_ready = 1'b0;
        for (int b = 0; b < 2; b++) begin
            mem_resp_valid = 1'b1;
            mem_resp_data  = mem_word(32'h1C0, b);
            step();
        end
        mem_resp_valid = 1'b1;
        mem_resp_data  = 32'hBAD0BAD0;
        reset          = 1'b1;
        settle();
        check("midrst_hit", 32'(hit), 32'd0);
        check("midrst_req_valid", 32'(mem_req_valid), 32'd0);
        step();
        addr = 32'h80;
        settle();
        check("midrst_valid_cleared", 32'(hit), 32'd0);
        step();
        reset         = 1'b0;
        addr          = 32'h1C0;
        mem_resp_data = 32'hBAD1BAD1;
        settle();
        check("postrst_hit", 32'(hit), 32'd0);
        check("postrst_req_valid", 32'(mem_req_valid), 32'd0);
        step();
        mem_resp_valid = 1'b0;
        fill_line(32'h1C0, 0, 0, -1);
        check_line(32'h1C0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
